machine_stim_checker: RTL and testbench
=======================================

Name: machine_stim_checker

Overview:
Self-timed, synthesisable stimulus generator and response checker for the Machine family of DUTs. Replaces the fixed-length, undriven-stimulus testbench with a generalised block: it drives a parametrised-width stimulus vector (exhaustive counter or LFSR mode) and compares the DUT result against a golden-model result after a configurable pipeline latency. It counts mismatches and raises done/pass. It sits beside the DUT and golden model inside a bench top level, and can also run on FPGA.

Parameters:
IN_W, 2, stimulus width (x), 1..16
OUT_W, 1, result width, 1..32
NUM_VEC, 4, number of vectors applied per run, >=1
LATENCY, 0, DUT/golden pipeline depth in cycles, 0..15
MODE, 0, 0 = incrementing counter from 0, 1 = Galois LFSR seeded with SEED
SEED, 1, LFSR seed, must be non-zero
CNT_W, 8, width of the error counter

Ports:
system1000  in  1  clock, rising edge
system1000_rstn  in  1  asynchronous active-low reset
start  in  1  pulse; begins a run when idle or done
x  out  IN_W  stimulus to the DUT and golden model
result  in  OUT_W  DUT response
expected  in  OUT_W  golden-model response
busy  out  1  high during RUN and DRAIN
done  out  1  sticky high after a run completes, until the next start
pass  out  1  valid when done=1; 1 iff err_count==0
err_count  out  CNT_W  mismatches in the current or last run, saturating
first_err  out  IN_W  x value of the first mismatch; 0 if none

Behaviour:
- Reset (async assert, sync release): state=IDLE, x=0 (MODE 0) or SEED (MODE 1), busy=0, done=0, pass=0, err_count=0, first_err=0, vector index=0, valid pipe cleared.
- FSM IDLE -> RUN on start. RUN -> DRAIN after NUM_VEC vectors issued. DRAIN -> DONE once the last valid exits the pipe (LATENCY cycles, 0 when LATENCY=0). DONE -> RUN on start.
- On start: x reloads to 0/SEED, err_count, first_err and done clear, and the first vector is presented on the same edge. Vector k is therefore stable during cycle k of RUN.
- x advances one step per RUN cycle. MODE 0 wraps modulo 2^IN_W. MODE 1 uses a maximal-length tap table for IN_W 2..16; IN_W=1 falls back to toggling.
- Valid pipe is LATENCY deep. The compare for vector k happens in cycle k+LATENCY: mismatch when result != expected, with X/Z treated as a mismatch in simulation via the case-inequality operator.
- On a mismatch, err_count increments and saturates at 2^CNT_W-1. On the first mismatch of a run, first_err captures the x that produced it, delayed through a LATENCY-deep x pipe.
- done and pass update on the DRAIN->DONE edge, or RUN->DONE when LATENCY=0. pass = (err_count==0) including a mismatch in the final compare.
- start while busy is ignored.
- Reset mid-run aborts immediately to the reset values. No partial done.
- Simulation only (translate_off): $finish one cycle after done rises, when the SIM_FINISH define is set.

Test Plan:
- IN_W=2, MODE 0, NUM_VEC=4, LATENCY=0; result tied to expected; start pulse -> x sequence 0,1,2,3; done high in cycle 5 after start; pass=1; err_count=0.
- As above, but force expected!=result only when x==2 -> err_count=1, first_err=2, pass=0.
- LATENCY=3, DUT model delays by 3, NUM_VEC=8, IN_W=3 -> busy held for 11 cycles, pass=1. Repeat with the model delayed by 2 -> mismatches detected, pass=0.
- MODE 1, IN_W=4, SEED=1, NUM_VEC=15 -> x visits all 15 non-zero values exactly once. A second start reproduces an identical sequence.
- CNT_W=2, always-mismatch, NUM_VEC=10 -> err_count saturates at 3; first_err=first vector.
- Deassert system1000_rstn in RUN cycle 2 -> all outputs return to reset values asynchronously. A later start runs the full NUM_VEC from the beginning; start during busy has no effect.

Source files
------------

// File: rtl/machine_stim_checker.sv
// ============================================================================
// Module  : machine_stim_checker
// Brief   : Self-timed stimulus generator (counter or Galois LFSR) and
//           latency-aligned result/expected checker with pass/fail summary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module machine_stim_checker #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1,
  parameter int NUM_VEC = 4,
  parameter int LATENCY = 0,
  parameter int MODE    = 0,
  parameter int SEED    = 1,
  parameter int CNT_W   = 8
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             start,
  output logic [IN_W-1:0]  x,
  input  logic [OUT_W-1:0] result,
  input  logic [OUT_W-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IN_W-1:0]  first_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int                c_IDX_W      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_VEC - 1);
  localparam logic [3:0]         c_DRAIN_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [IN_W-1:0]    c_X_INIT    = (MODE == 1) ? IN_W'(SEED) : '0;

  // Right-shift Galois toggle masks of maximal-length polynomials.
  function automatic logic [15:0] f_taps(input int w);
    case (w)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [IN_W-1:0] c_TAPS = IN_W'(f_taps(IN_W));

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_IDX_W-1:0] r_idx;
  logic [3:0]         r_drain;
  logic [IN_W-1:0]    r_x;
  logic [IN_W-1:0]    w_x_step;
  logic [CNT_W-1:0]   r_err;
  logic [IN_W-1:0]    r_first;
  logic               w_run;
  logic               w_start_ok;
  logic               w_last_vec;
  logic               w_cmp_valid;
  logic [IN_W-1:0]    w_cmp_x;
  logic               w_mismatch;

  assign w_run      = (r_state == S_RUN);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_vec = (r_idx == c_LAST_IDX);

  generate
    if (MODE == 1) begin : g_lfsr
      if (IN_W == 1) begin : g_toggle
        assign w_x_step = ~r_x;
      end else begin : g_galois
        assign w_x_step = (r_x >> 1) ^ ({IN_W{r_x[0]}} & c_TAPS);
      end
    end else begin : g_count
      assign w_x_step = r_x + IN_W'(1);
    end
  endgenerate

  // Valid and x travel together so a late compare can name its stimulus.
  generate
    if (LATENCY > 0) begin : g_pipe
      logic            r_vpipe [LATENCY];
      logic [IN_W-1:0] r_xpipe [LATENCY];
      always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
          for (int i = 0; i < LATENCY; i++) begin
            r_vpipe[i] <= 1'b0;
            r_xpipe[i] <= '0;
          end
        end else begin
          r_vpipe[0] <= w_run;
          r_xpipe[0] <= r_x;
          for (int i = 1; i < LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
            r_xpipe[i] <= r_xpipe[i-1];
          end
        end
      end
      assign w_cmp_valid = r_vpipe[LATENCY-1];
      assign w_cmp_x     = r_xpipe[LATENCY-1];
    end else begin : g_nopipe
      assign w_cmp_valid = w_run;
      assign w_cmp_x     = r_x;
    end
  endgenerate

  assign w_mismatch = w_cmp_valid && (result !== expected);

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
      S_RUN:          if (w_last_vec) w_state_nxt = (LATENCY == 0) ? S_DONE : S_DRAIN;
      S_DRAIN:        if (r_drain == c_DRAIN_LAST) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // err_count is final once DONE is reached, so pass can be decoded from it.
  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
    pass = (r_state == S_DONE) && (r_err == '0);
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_idx   <= '0;
      r_drain <= '0;
      r_x     <= c_X_INIT;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      if (w_start_ok) begin
        r_idx <= '0;
        r_x   <= c_X_INIT;
      end else if (w_run && !w_last_vec) begin
        r_idx <= r_idx + c_IDX_W'(1);
        r_x   <= w_x_step;
      end

      if (w_run)                     r_drain <= '0;
      else if (r_state == S_DRAIN)   r_drain <= r_drain + 4'd1;

      if (w_start_ok) begin
        r_err   <= '0;
        r_first <= '0;
      end else if (w_mismatch) begin
        if (r_err == '0) r_first <= w_cmp_x;
        if (r_err != '1) r_err   <= r_err + CNT_W'(1);
      end
    end
  end

  assign x         = r_x;
  assign err_count = r_err;
  assign first_err = r_first;

`ifdef SIM_FINISH
`ifndef SYNTHESIS
  logic r_sim_done_q;
  always_ff @(posedge system1000) begin
    r_sim_done_q <= done;
    if (done && !r_sim_done_q) $finish;
  end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_machine_stim_checker.sv
// ============================================================================
// Module  : tb_machine_stim_checker
// Brief   : Randomised self-checking bench for two checker configurations
//           (LFSR with latency, counter without latency) against a run model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_machine_stim_checker;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b1;
  logic       start = 1'b0;
  logic [3:0] resA  = '0, expA = '0;
  logic       resB  = 1'b0, expB = 1'b0;

  logic [3:0] xA, firstA;
  logic [2:0] errA;
  logic       busyA, doneA, passA;
  logic [2:0] xB, firstB;
  logic [1:0] errB;
  logic       busyB, doneB, passB;

  always #5 clk = ~clk;

  machine_stim_checker #(.IN_W(4), .OUT_W(4), .NUM_VEC(15), .LATENCY(2),
                         .MODE(1), .SEED(1), .CNT_W(3)) dut_a (
    .system1000(clk), .system1000_rstn(rstn), .start(start), .x(xA),
    .result(resA), .expected(expA), .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .first_err(firstA));

  machine_stim_checker #(.IN_W(3), .OUT_W(1), .NUM_VEC(10), .LATENCY(0),
                         .MODE(0), .SEED(1), .CNT_W(2)) dut_b (
    .system1000(clk), .system1000_rstn(rstn), .start(start), .x(xB),
    .result(resB), .expected(expB), .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .first_err(firstB));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int inj_mode = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference run model: per-instance vector count, latency and saturation.
  localparam int NV  [2] = '{15, 10};
  localparam int LAT [2] = '{2, 0};
  localparam int MAXE[2] = '{7, 3};
  int lfsr_tab[15] = '{1, 12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9, 8, 4, 2};

  function automatic int seq(input int i, input int k);
    if (i == 0) return lfsr_tab[k % 15];
    return k % 8;
  endfunction

  int m_t[2], m_err[2], m_first[2];
  bit m_busy[2], m_done[2], m_pass[2], m_fresh[2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_t[i] = 0; m_err[i] = 0; m_first[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fresh[i] = 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit mis;
        mis = (i == 0) ? (resA != expA) : (resB != expB);
        if (m_busy[i]) begin
          if (m_t[i] >= LAT[i] && mis) begin
            if (m_err[i] == 0) m_first[i] = seq(i, m_t[i] - LAT[i]);
            if (m_err[i] < MAXE[i]) m_err[i]++;
          end
          m_t[i]++;
          if (m_t[i] == NV[i] + LAT[i]) begin
            m_busy[i] = 0; m_done[i] = 1; m_pass[i] = (m_err[i] == 0);
          end
        end else if (start) begin
          m_busy[i] = 1; m_t[i] = 0; m_err[i] = 0; m_first[i] = 0;
          m_done[i] = 0; m_pass[i] = 0; m_fresh[i] = 0;
        end
      end
    end
  end

  // Response drive: mismatches are injected per mode, independent of the DUT.
  always @(negedge clk) begin
    bit ma, mb;
    ma = 0; mb = 0;
    case (inj_mode)
      1: begin ma = m_busy[0] && m_t[0] == 5; mb = m_busy[1] && m_t[1] == 2; end
      2: begin ma = 1; mb = 1; end
      3: begin ma = ($urandom_range(0, 2) == 0); mb = ($urandom_range(0, 2) == 0); end
      default: ;
    endcase
    resA = 4'($urandom_range(0, 15));
    expA = ma ? (resA ^ 4'($urandom_range(1, 15))) : resA;
    resB = 1'($urandom_range(0, 1));
    expB = resB ^ mb;
  end

  task automatic cmp_inst(input int i, input int bsy, input int dn, input int ps,
                          input int er, input int fe, input int xv);
    check($sformatf("busy%0d", i), bsy, int'(m_busy[i]));
    check($sformatf("done%0d", i), dn, int'(m_done[i]));
    check($sformatf("err_count%0d", i), er, m_err[i]);
    check($sformatf("first_err%0d", i), fe, m_first[i]);
    if (m_done[i]) check($sformatf("pass%0d", i), ps, int'(m_pass[i]));
    if (m_busy[i] && m_t[i] < NV[i]) check($sformatf("x_run%0d", i), xv, seq(i, m_t[i]));
    if (m_fresh[i]) check($sformatf("x_idle%0d", i), xv, seq(i, 0));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, busyA, doneA, passA, errA, firstA, xA);
      cmp_inst(1, busyB, doneB, passB, errB, firstB, xB);
    end
  end

  task automatic run_and_wait(input bit extra_start, output int ba, output int bb);
    ba = 0; bb = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busyA) ba++;
      if (busyB) bb++;
      if (doneA && doneB) break;
      start = extra_start && (c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("run_completes", int'(doneA && doneB), 1);
  endtask

  initial begin
    int ba, bb;
    #2 rstn = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_xA", xA, 1);
    check("rst_xB", xB, 0);
    check("rst_busy", int'(busyA | busyB), 0);
    check("rst_done", int'(doneA | doneB), 0);
    check("rst_pass", int'(passA | passB), 0);
    #2 rstn = 1'b1;
    @(negedge clk);

    inj_mode = 0;
    run_and_wait(1'b0, ba, bb);
    check("clean_busyA_cycles", ba, 17);
    check("clean_busyB_cycles", bb, 10);
    check("clean_passA", passA, 1);
    check("clean_passB", passB, 1);
    check("clean_errA", errA, 0);

    inj_mode = 1;
    run_and_wait(1'b0, ba, bb);
    check("one_errA", errA, 1);
    check("one_firstA", firstA, 3);
    check("one_passA", passA, 0);
    check("one_errB", errB, 1);
    check("one_firstB", firstB, 2);
    check("one_passB", passB, 0);

    inj_mode = 2;
    run_and_wait(1'b0, ba, bb);
    check("sat_errA", errA, 7);
    check("sat_firstA", firstA, 1);
    check("sat_errB", errB, 3);
    check("sat_firstB", firstB, 0);

    inj_mode = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_busy", int'(busyA | busyB), 0);
    check("abort_done", int'(doneA | doneB), 0);
    check("abort_err", int'(errA) + int'(errB), 0);
    check("abort_xA", xA, 1);
    check("abort_xB", xB, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    inj_mode = 0;
    run_and_wait(1'b1, ba, bb);
    check("rerun_busyA_cycles", ba, 17);
    check("rerun_busyB_cycles", bb, 10);
    check("rerun_passA", passA, 1);

    inj_mode = 3;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
